// File: rtl/bridge_pkg.sv
// Shared constants and types for the sram-to-AXI bridge.
// Fixed AXI IDs, burst tie-offs and the write-path state encoding.
package bridge_pkg;

  localparam logic [3:0] ID_INST        = 4'd0;
  localparam logic [3:0] ID_DATA        = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_1      = 8'd0;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/bridge_wr_ctrl.sv
// Single-beat write sequencer for the data port.
// Drives AW and W independently, then waits for the B response.
module bridge_wr_ctrl
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        done
);

  wr_state_e   state_q, state_d;
  logic [31:0] aw_addr_q;
  logic [1:0]  aw_size_q;
  logic        aw_valid_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        w_valid_q;
  logic        load;

  assign load = accept & (state_q == W_IDLE);

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      W_IDLE: if (accept) state_d = W_SEND;
      // Each channel is finished once its valid is low or handshaking this cycle.
      W_SEND: if ((~aw_valid_q | awready) & (~w_valid_q | wready)) state_d = W_RESP;
      W_RESP: begin
        if (bvalid) begin
          done    = 1'b1;
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= W_IDLE;
      aw_addr_q  <= '0;
      aw_size_q  <= '0;
      aw_valid_q <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      w_valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        aw_addr_q  <= req_addr;
        aw_size_q  <= req_size;
        aw_valid_q <= 1'b1;
        w_data_q   <= req_wdata;
        w_strb_q   <= req_wstrb;
        w_valid_q  <= 1'b1;
      end else begin
        if (aw_valid_q & awready) aw_valid_q <= 1'b0;
        if (w_valid_q & wready)   w_valid_q  <= 1'b0;
      end
    end
  end

  assign awaddr  = aw_addr_q;
  assign awsize  = {1'b0, aw_size_q};
  assign awvalid = aw_valid_q;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wvalid  = w_valid_q;

endmodule

// File: rtl/sram_axi_bridge.sv
// Merges the instruction and data sram-like ports onto one AXI master.
// Reads share a single AR slot (data wins); read data is steered back by rid[0].
module sram_axi_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned INST_MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [3:0] InstMax = 4'(INST_MAX_OUT);

  logic        ar_valid_q;
  logic [3:0]  ar_id_q;
  logic [31:0] ar_addr_q;
  logic [1:0]  ar_size_q;
  logic [3:0]  inst_cnt_q, inst_cnt_d;
  logic        data_busy_q;
  logic        slot_free, data_rd_grant, inst_grant, data_wr_accept;
  logic        inst_inc, inst_dec, wr_done;

  assign slot_free      = ~ar_valid_q;
  assign data_rd_grant  = slot_free & data_sram_req & ~data_sram_wr & ~data_busy_q;
  assign inst_grant     = slot_free & ~data_rd_grant & inst_sram_req & (inst_cnt_q < InstMax);
  assign data_wr_accept = data_sram_req & data_sram_wr & ~data_busy_q;

  assign inst_sram_addr_ok = inst_grant;
  assign data_sram_addr_ok = data_rd_grant | data_wr_accept;
  assign inst_sram_data_ok = rvalid & ~rid[0];
  assign data_sram_data_ok = (rvalid & rid[0]) | wr_done;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  // A response with nothing outstanding is dropped so the counter cannot wrap.
  assign inst_inc = inst_grant;
  assign inst_dec = inst_sram_data_ok & (inst_cnt_q != 4'd0);

  always_comb begin
    inst_cnt_d = inst_cnt_q;
    if (inst_inc & ~inst_dec)      inst_cnt_d = inst_cnt_q + 4'd1;
    else if (~inst_inc & inst_dec) inst_cnt_d = inst_cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_valid_q  <= 1'b0;
      ar_id_q     <= '0;
      ar_addr_q   <= '0;
      ar_size_q   <= '0;
      inst_cnt_q  <= '0;
      data_busy_q <= 1'b0;
    end else begin
      inst_cnt_q <= inst_cnt_d;
      if (data_rd_grant | inst_grant) begin
        ar_valid_q <= 1'b1;
        ar_id_q    <= data_rd_grant ? ID_DATA : ID_INST;
        ar_addr_q  <= data_rd_grant ? data_sram_addr : inst_sram_addr;
        ar_size_q  <= data_rd_grant ? data_sram_size : inst_sram_size;
      end else if (ar_valid_q & arready) begin
        ar_valid_q <= 1'b0;
      end
      if (data_sram_addr_ok)      data_busy_q <= 1'b1;
      else if (data_sram_data_ok) data_busy_q <= 1'b0;
    end
  end

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = {1'b0, ar_size_q};
  assign arvalid = ar_valid_q;
  assign arlen   = AXI_LEN_1;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign rready  = 1'b1;

  assign awid    = ID_DATA;
  assign awlen   = AXI_LEN_1;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;
  assign bready  = 1'b1;

  bridge_wr_ctrl u_wr_ctrl (
    .clk       (clk),
    .reset     (reset),
    .accept    (data_wr_accept),
    .req_addr  (data_sram_addr),
    .req_size  (data_sram_size),
    .req_wdata (data_sram_wdata),
    .req_wstrb (data_sram_wstrb),
    .awaddr    (awaddr),
    .awsize    (awsize),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .done      (wr_done)
  );

  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid[3:1], rresp,
                           rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed and randomized checks of sram_axi_bridge against a transaction-level model.
module tb_sram_axi_bridge;

  localparam int MaxOut = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, rid, awid, wid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int total = 0;
  int bad   = 0;

  logic [3:0]  ar_id_q[$];
  logic [31:0] ar_addr_q[$];
  logic [1:0]  ar_size_q[$];
  logic [3:0]  r_id_q[$];
  logic [31:0] r_addr_q[$];
  logic [31:0] inst_addr_q[$];

  sram_axi_bridge #(.INST_MAX_OUT(MaxOut)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    #1;
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b want=0", arvalid); end
    total++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin
      bad++; $display("FAIL rst_awvalid_wvalid got=%b%b want=00", awvalid, wvalid); end
    total++; if (rready !== 1'b1 || bready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b%b want=11", rready, bready); end
    total++; if (arlen !== 8'd0 || arburst !== 2'b01 || awid !== 4'd1 || wid !== 4'd1 ||
                 wlast !== 1'b1) begin
      bad++; $display("FAIL tieoffs arlen=%h arburst=%b awid=%h wid=%h wlast=%b",
                      arlen, arburst, awid, wid, wlast); end
    reset = 1'b0;
    step();
    #1;
    total++; if (arvalid !== 1'b0 || inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
      bad++; $display("FAIL post_rst_idle got arvalid=%b ido=%b ddo=%b want=000",
                      arvalid, inst_sram_data_ok, data_sram_data_ok); end
    step();
  endtask

  task automatic test_inst_read();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b1) begin
      bad++; $display("FAIL ird_addr_ok got=%b want=1", inst_sram_addr_ok); end
    step();
    inst_sram_req = 0; arready = 1;
    #1;
    total++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h1C00_0000 || arsize !== 3'd2)
      begin bad++; $display("FAIL ird_ar got v=%b id=%h a=%h s=%h want 1/0/1c000000/2",
                            arvalid, arid, araddr, arsize); end
    step();
    arready = 0;
    #1;
    total++; if (arvalid !== 1'b0 || inst_sram_data_ok !== 1'b0) begin
      bad++; $display("FAIL ird_gap got arvalid=%b dok=%b want=00", arvalid, inst_sram_data_ok); end
    step();
    rvalid = 1; rid = 0; rdata = 32'h0280_0000;
    #1;
    total++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h0280_0000 ||
                 data_sram_data_ok !== 1'b0) begin
      bad++; $display("FAIL ird_data got ok=%b d=%h dok=%b want 1/02800000/0",
                      inst_sram_data_ok, inst_sram_rdata, data_sram_data_ok); end
    step();
    rvalid = 0;
    #1;
    total++; if (inst_sram_data_ok !== 1'b0) begin
      bad++; $display("FAIL ird_single_pulse got=%b want=0", inst_sram_data_ok); end
    step();
  endtask

  task automatic test_priority();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0040;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1C00_9000;
    #1;
    total++; if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin
      bad++; $display("FAIL prio_grant got d=%b i=%b want d=1 i=0", data_sram_addr_ok,
                      inst_sram_addr_ok); end
    step();
    data_sram_req = 0; arready = 1;
    #1;
    total++; if (arid !== 4'd1 || araddr !== 32'h1C00_9000 || inst_sram_addr_ok !== 1'b0) begin
      bad++; $display("FAIL prio_ar_data got id=%h a=%h iok=%b want 1/1c009000/0",
                      arid, araddr, inst_sram_addr_ok); end
    step();
    arready = 0;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b1) begin
      bad++; $display("FAIL prio_inst_next got=%b want=1", inst_sram_addr_ok); end
    step();
    inst_sram_req = 0; arready = 1;
    #1;
    total++; if (arid !== 4'd0 || araddr !== 32'h1C00_0040) begin
      bad++; $display("FAIL prio_ar_inst got id=%h a=%h want 0/1c000040", arid, araddr); end
    step();
    arready = 0; rvalid = 1; rid = 1; rdata = 32'h1111_2222;
    #1;
    total++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== 32'h1111_2222 ||
                 inst_sram_data_ok !== 1'b0) begin
      bad++; $display("FAIL prio_rd_data got dok=%b d=%h iok=%b want 1/11112222/0",
                      data_sram_data_ok, data_sram_rdata, inst_sram_data_ok); end
    step();
    rid = 0; rdata = 32'h3333_4444;
    step();
    rvalid = 0;
  endtask

  task automatic test_inst_limit();
    int grants = 0;
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0100; arready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (inst_sram_addr_ok === 1'b1) grants++;
      step();
    end
    total++; if (grants != MaxOut) begin
      bad++; $display("FAIL lim_grants got=%0d want=%0d", grants, MaxOut); end
    rvalid = 1; rid = 0; rdata = 32'h0000_00AA;
    #1;
    total++; if (inst_sram_data_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin
      bad++; $display("FAIL lim_first_r got dok=%b aok=%b want 1/0", inst_sram_data_ok,
                      inst_sram_addr_ok); end
    step();
    rvalid = 0;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b1) begin
      bad++; $display("FAIL lim_third_grant got=%b want=1", inst_sram_addr_ok); end
    step();
    inst_sram_req = 0;
    step();
    rvalid = 1;
    step();
    step();
    rvalid = 0; arready = 0;
  endtask

  task automatic test_write();
    int aw_n = 0;
    int w_n  = 0;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1C00_8000;
    data_sram_wdata = 32'hDEAD_BEEF; data_sram_wstrb = 4'b0011; data_sram_size = 2'd2;
    #1;
    total++; if (data_sram_addr_ok !== 1'b1) begin
      bad++; $display("FAIL wr_addr_ok got=%b want=1", data_sram_addr_ok); end
    step();
    data_sram_req = 0;
    for (int i = 0; i < 6; i++) begin
      awready = (i == 0); wready = (i == 4);
      #1;
      if (awvalid && awready) begin
        aw_n++;
        total++; if (awaddr !== 32'h1C00_8000 || awsize !== 3'd2) begin
          bad++; $display("FAIL wr_aw got a=%h s=%h want 1c008000/2", awaddr, awsize); end
      end
      if (wvalid && wready) begin
        w_n++;
        total++; if (wdata !== 32'hDEAD_BEEF || wstrb !== 4'b0011) begin
          bad++; $display("FAIL wr_w got d=%h s=%b want deadbeef/0011", wdata, wstrb); end
      end
      total++; if (data_sram_data_ok !== 1'b0) begin
        bad++; $display("FAIL wr_early_dok cyc=%0d got=1 want=0", i); end
      step();
    end
    awready = 0; wready = 0;
    total++; if (aw_n != 1 || w_n != 1) begin
      bad++; $display("FAIL wr_beats got aw=%0d w=%0d want 1/1", aw_n, w_n); end
    #1;
    total++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || data_sram_data_ok !== 1'b0) begin
      bad++; $display("FAIL wr_resp_wait got aw=%b w=%b dok=%b want 000", awvalid, wvalid,
                      data_sram_data_ok); end
    step();
    bvalid = 1; bid = 1;
    #1;
    total++; if (data_sram_data_ok !== 1'b1) begin
      bad++; $display("FAIL wr_bvalid_dok got=%b want=1", data_sram_data_ok); end
    step();
    bvalid = 0;
  endtask

  task automatic test_read_after_write();
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1C00_8004;
    data_sram_wdata = 32'h1234_5678; data_sram_wstrb = 4'hF;
    step();
    data_sram_req = 0; awready = 1; wready = 1;
    step();
    awready = 0; wready = 0;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1C00_8004;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (data_sram_addr_ok !== 1'b0) begin
        bad++; $display("FAIL raw_blocked cyc=%0d got=1 want=0", i); end
      step();
    end
    bvalid = 1; bid = 1;
    #1;
    total++; if (data_sram_data_ok !== 1'b1 || data_sram_addr_ok !== 1'b0) begin
      bad++; $display("FAIL raw_wr_done got dok=%b aok=%b want 1/0", data_sram_data_ok,
                      data_sram_addr_ok); end
    step();
    bvalid = 0;
    #1;
    total++; if (data_sram_addr_ok !== 1'b1) begin
      bad++; $display("FAIL raw_rd_grant got=%b want=1", data_sram_addr_ok); end
    step();
    data_sram_req = 0; arready = 1;
    #1;
    total++; if (arid !== 4'd1 || araddr !== 32'h1C00_8004) begin
      bad++; $display("FAIL raw_ar got id=%h a=%h want 1/1c008004", arid, araddr); end
    step();
    arready = 0; rvalid = 1; rid = 1;
    step();
    rvalid = 0;
  endtask

  task automatic test_spurious();
    int grants = 0;
    rvalid = 1; rid = 0;
    step();
    rvalid = 0;
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0200; arready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (inst_sram_addr_ok === 1'b1) grants++;
      step();
    end
    total++; if (grants != MaxOut) begin
      bad++; $display("FAIL spurious_no_underflow got=%0d want=%0d", grants, MaxOut); end
    inst_sram_req = 0; arready = 0; rvalid = 1; rid = 0;
    step();
    step();
    rvalid = 0;
  endtask

  task automatic test_reset_midflight();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0300; arready = 1;
    repeat (4) step();
    inst_sram_req = 0; arready = 0;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1C00_A000;
    #1;
    total++; if (data_sram_addr_ok !== 1'b1) begin
      bad++; $display("FAIL mid_setup got=%b want=1", data_sram_addr_ok); end
    step();
    data_sram_req = 0;
    #1;
    reset = 1;
    #1;
    total++; if (arvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
      bad++; $display("FAIL mid_async_clear got ar=%b aw=%b w=%b want 000", arvalid, awvalid,
                      wvalid); end
    step();
    reset = 0;
    data_sram_req = 1; data_sram_addr = 32'h1C00_A100;
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0400;
    #1;
    total++; if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin
      bad++; $display("FAIL mid_after_rst got d=%b i=%b want 1/0", data_sram_addr_ok,
                      inst_sram_addr_ok); end
    step();
    data_sram_req = 0; arready = 1;
    #1;
    total++; if (arid !== 4'd1 || araddr !== 32'h1C00_A100) begin
      bad++; $display("FAIL mid_ar got id=%h a=%h want 1/1c00a100", arid, araddr); end
    step();
    arready = 0;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b1) begin
      bad++; $display("FAIL mid_inst_cnt_cleared got=%b want=1", inst_sram_addr_ok); end
    step();
    inst_sram_req = 0; arready = 1;
    step();
    arready = 0; rvalid = 1; rid = 1;
    step();
    rid = 0;
    step();
    rvalid = 0;
  endtask

  task automatic test_random();
    logic slot_free, d_rd_win, e_daok, e_iaok, e_idok, e_ddok, inst_acc, data_acc;
    logic busy_m, aw_pend, w_pend, aw_got, w_got;
    logic [31:0] d_addr_m, w_addr_m, w_data_m;
    logic [3:0]  w_strb_m;
    int inst_out;
    busy_m = 0; aw_pend = 0; w_pend = 0; aw_got = 0; w_got = 0; inst_out = 0;
    d_addr_m = 0; w_addr_m = 0; w_data_m = 0; w_strb_m = 0;
    idle();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!inst_sram_req && $urandom_range(0, 2) == 0) begin
        inst_sram_req = 1; inst_sram_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_sram_req && $urandom_range(0, 3) == 0) begin
        data_sram_req = 1; data_sram_wr = 1'($urandom_range(0, 1));
        data_sram_addr = $urandom; data_sram_wdata = $urandom;
        data_sram_wstrb = 4'($urandom); data_sram_size = 2'($urandom_range(0, 2));
      end
      arready = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      if (r_id_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        rvalid = 1; rid = r_id_q[0]; rdata = exp_word(r_addr_q[0]);
      end else begin
        rvalid = 0; rid = 4'($urandom_range(0, 1)); rdata = $urandom;
      end
      bvalid = aw_got && w_got && ($urandom_range(0, 1) == 1); bid = 1;
      #1;
      slot_free = (ar_id_q.size() == 0);
      d_rd_win  = data_sram_req && !data_sram_wr && !busy_m && slot_free;
      e_daok    = d_rd_win || (data_sram_req && data_sram_wr && !busy_m);
      e_iaok    = inst_sram_req && slot_free && !d_rd_win && (inst_out < MaxOut);
      e_idok    = rvalid && !rid[0];
      e_ddok    = (rvalid && rid[0]) || bvalid;
      total++; if (inst_sram_addr_ok !== e_iaok) begin
        bad++; $display("FAIL rnd_inst_addr_ok cyc=%0d got=%b want=%b", cyc, inst_sram_addr_ok,
                        e_iaok); end
      total++; if (data_sram_addr_ok !== e_daok) begin
        bad++; $display("FAIL rnd_data_addr_ok cyc=%0d got=%b want=%b", cyc, data_sram_addr_ok,
                        e_daok); end
      total++; if (arvalid !== !slot_free) begin
        bad++; $display("FAIL rnd_arvalid cyc=%0d got=%b want=%b", cyc, arvalid, !slot_free); end
      total++; if (inst_sram_data_ok !== e_idok || data_sram_data_ok !== e_ddok) begin
        bad++; $display("FAIL rnd_data_ok cyc=%0d got i=%b d=%b want i=%b d=%b", cyc,
                        inst_sram_data_ok, data_sram_data_ok, e_idok, e_ddok); end
      total++; if (awvalid !== aw_pend || wvalid !== w_pend) begin
        bad++; $display("FAIL rnd_wvalids cyc=%0d got aw=%b w=%b want aw=%b w=%b", cyc,
                        awvalid, wvalid, aw_pend, w_pend); end
      if (!slot_free && arready) begin
        total++; if (arid !== ar_id_q[0] || araddr !== ar_addr_q[0] ||
                     arsize !== {1'b0, ar_size_q[0]}) begin
          bad++; $display("FAIL rnd_ar cyc=%0d got id=%h a=%h s=%h want id=%h a=%h s=%h", cyc,
                          arid, araddr, arsize, ar_id_q[0], ar_addr_q[0], ar_size_q[0]); end
        r_id_q.push_back(ar_id_q[0]);
        r_addr_q.push_back(araddr);
        void'(ar_id_q.pop_front()); void'(ar_addr_q.pop_front()); void'(ar_size_q.pop_front());
      end
      if (e_idok && inst_addr_q.size() > 0) begin
        total++; if (inst_sram_rdata !== exp_word(inst_addr_q[0])) begin
          bad++; $display("FAIL rnd_inst_rdata cyc=%0d got=%h want=%h", cyc, inst_sram_rdata,
                          exp_word(inst_addr_q[0])); end
        void'(inst_addr_q.pop_front());
      end
      if (rvalid && rid[0]) begin
        total++; if (data_sram_rdata !== exp_word(d_addr_m)) begin
          bad++; $display("FAIL rnd_data_rdata cyc=%0d got=%h want=%h", cyc, data_sram_rdata,
                          exp_word(d_addr_m)); end
      end
      if (aw_pend && awready) begin
        total++; if (awaddr !== w_addr_m) begin
          bad++; $display("FAIL rnd_awaddr cyc=%0d got=%h want=%h", cyc, awaddr, w_addr_m); end
        aw_pend = 0; aw_got = 1;
      end
      if (w_pend && wready) begin
        total++; if (wdata !== w_data_m || wstrb !== w_strb_m) begin
          bad++; $display("FAIL rnd_w cyc=%0d got d=%h s=%b want d=%h s=%b", cyc, wdata, wstrb,
                          w_data_m, w_strb_m); end
        w_pend = 0; w_got = 1;
      end
      if (rvalid) begin
        void'(r_id_q.pop_front()); void'(r_addr_q.pop_front());
        if (!rid[0]) inst_out--;
        else busy_m = 0;
      end
      if (bvalid) begin
        aw_got = 0; w_got = 0; busy_m = 0;
      end
      inst_acc = e_iaok;
      data_acc = e_daok;
      if (e_iaok) begin
        ar_id_q.push_back(4'd0); ar_addr_q.push_back(inst_sram_addr);
        ar_size_q.push_back(inst_sram_size); inst_addr_q.push_back(inst_sram_addr);
        inst_out++;
      end
      if (e_daok) begin
        busy_m = 1;
        if (data_sram_wr) begin
          aw_pend = 1; w_pend = 1;
          w_addr_m = data_sram_addr; w_data_m = data_sram_wdata; w_strb_m = data_sram_wstrb;
        end else begin
          d_addr_m = data_sram_addr;
          ar_id_q.push_back(4'd1); ar_addr_q.push_back(data_sram_addr);
          ar_size_q.push_back(data_sram_size);
        end
      end
      step();
      if (inst_acc) inst_sram_req = 0;
      if (data_acc) data_sram_req = 0;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_priority();
    test_inst_limit();
    test_write();
    test_read_after_write();
    test_spurious();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
